// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: default bus
// widths, run-counter sizing and the response FSM state encoding.
package mem_port_arbiter_pkg;

    localparam int ABITS_DEF  = 12;
    localparam int DBITS_DEF  = 16;
    localparam int MAXRUN_DEF = 3;

    // Run counter is 3 bits wide, so MAXRUN may range 0..7.
    localparam int RUN_BITS = 3;

    // Type of the access issued in the previous cycle; decides which
    // requester receives the memory's synchronous read data this cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_F = 2'd1,
        ST_RD_D = 2'd2,
        ST_WR_D = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-array signals around the arbiter.
// master: pipeline stages plus memory array; slave: the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int ABITS = mem_port_arbiter_pkg::ABITS_DEF,
    parameter int DBITS = mem_port_arbiter_pkg::DBITS_DEF
) ();

    logic             f_req;
    logic [ABITS-1:0] f_addr;
    logic             f_gnt;
    logic             f_rvalid;
    logic [DBITS-1:0] f_rdata;

    logic             d_req;
    logic             d_we;
    logic [ABITS-1:0] d_addr;
    logic [DBITS-1:0] d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [DBITS-1:0] d_rdata;

    logic [ABITS-1:0] m_addr;
    logic             m_we;
    logic [DBITS-1:0] m_din;
    logic [DBITS-1:0] m_dout;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_dout,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_we, m_din
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_dout,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_we, m_din
    );

endinterface

// File: rtl/mem_port_arbiter_run_limiter.sv
// Two-requester conflict resolver. The burst requester wins conflicts
// until it has taken MAXRUN consecutive grants while the waiting
// requester was pending; then the waiting requester is served once.
module run_limiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAXRUN = MAXRUN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_req,
    input  logic burst_req,
    output logic wait_gnt,
    output logic burst_gnt
);

    localparam logic [RUN_BITS-1:0] RUN_MAX = '1;

    logic [RUN_BITS-1:0] run;
    logic                burst_wins;

    // Winner selection; nothing is granted while reset is held.
    always_comb begin
        burst_wins = (run < RUN_BITS'(MAXRUN));
        wait_gnt   = ~rst & wait_req  & ~(burst_req & burst_wins);
        burst_gnt  = ~rst & burst_req & ~(wait_req & ~burst_wins);
    end

    // Count burst grants taken over a waiting requester; any other outcome clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= '0;
        end else if (wait_req && burst_req && burst_wins) begin
            run <= (run == RUN_MAX) ? run : run + 1'b1;
        end else begin
            run <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single read/write port of the unified instruction/data
// memory between fetch and load/store, one access per cycle, and routes
// the one-cycle-late read data back to whoever issued the read.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ABITS  = ABITS_DEF,
    parameter int DBITS  = DBITS_DEF,
    parameter int MAXRUN = MAXRUN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    arb_state_t       state;
    logic             f_gnt;
    logic             d_gnt;
    logic [ABITS-1:0] addr_sel;
    logic [ABITS-1:0] addr_hold;
    logic             f_rvalid;
    logic             d_rvalid;

    run_limiter #(
        .MAXRUN (MAXRUN)
    ) u_run_limiter (
        .clk       (clk),
        .rst       (rst),
        .wait_req  (bus.f_req),
        .burst_req (bus.d_req),
        .wait_gnt  (f_gnt),
        .burst_gnt (d_gnt)
    );

    // Memory address follows the winner; with no grant the last address is kept.
    always_comb begin
        addr_sel = addr_hold;
        if (f_gnt) begin
            addr_sel = bus.f_addr;
        end else if (d_gnt) begin
            addr_sel = bus.d_addr;
        end
    end

    // Remember the most recent address driven to the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold <= '0;
        end else begin
            addr_hold <= addr_sel;
        end
    end

    // Response FSM: record what was issued so next cycle's data goes to the right stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (f_gnt) begin
            state <= ST_RD_F;
        end else if (d_gnt) begin
            state <= bus.d_we ? ST_WR_D : ST_RD_D;
        end else begin
            state <= ST_IDLE;
        end
    end

    assign f_rvalid = (state == ST_RD_F);
    assign d_rvalid = (state == ST_RD_D);

    assign bus.f_gnt    = f_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.m_addr   = addr_sel;
    assign bus.m_we     = d_gnt & bus.d_we;
    assign bus.m_din    = bus.d_wdata;
    assign bus.f_rvalid = f_rvalid;
    assign bus.d_rvalid = d_rvalid;
    assign bus.f_rdata  = f_rvalid ? bus.m_dout : '0;
    assign bus.d_rdata  = d_rvalid ? bus.m_dout : '0;

endmodule
